// File: rtl/dsr_frame_feeder.sv
// dsr_frame_feeder: byte FIFO feeding a downstream sequencer frame by frame, with done/timeout handling
//
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-high reset
//   in_valid     - upstream byte valid
//   in_data      - upstream byte
//   in_ready     - FIFO not full
//   dsr_start    - registered one-cycle frame start (high during LAUNCH)
//   dsr_data     - registered byte stream to the sequencer
//   dsr_done     - frame-complete pulse, honoured only in FEED
//   busy         - FSM not in IDLE
//   timeout_err  - registered one-cycle pulse, high in the first RECOVER cycle
//   frame_cnt    - completed frames (wraps)
//   err_cnt      - timeouts (wraps)
//
// Build option: define DSR_FEEDER_STATS_EN to build frame_cnt/err_cnt counters;
// otherwise both outputs are tied to 8'h00.
module dsr_frame_feeder #(
    parameter int          DEPTH        = 4,
    parameter int          TIMEOUT      = 64,
    parameter int          RECOVER_CYC  = 4,
    parameter logic [7:0]  RECOVER_BYTE = 8'h17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       dsr_start,
    output logic [7:0] dsr_data,
    input  logic       dsr_done,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] frame_cnt,
    output logic [7:0] err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RECOVER_CYC + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, FEED, RECOVER} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] rec_q, rec_d;
    logic [7:0]    data_q, data_d;
    logic          start_q, start_d, terr_q, terr_d;
    logic          empty, full, push, pop, done_hit, tmo_hit;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty       = wr_q == rd_q;
    assign full        = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign in_ready    = !full;
    assign push        = in_valid && !full;
    assign busy        = state_q != IDLE;
    assign dsr_start   = start_q;
    assign dsr_data    = data_q;
    assign timeout_err = terr_q;

    // Done takes priority over an expiring timeout in the same cycle.
    assign done_hit = state_q == FEED && dsr_done;
    assign tmo_hit  = state_q == FEED && !dsr_done && tmo_q == TW'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        tmo_d   = tmo_q;
        rec_d   = rec_q;
        data_d  = data_q;
        terr_d  = 1'b0;
        pop     = 1'b0;
        wr_d    = wr_q + {{AW{1'b0}}, push};
        case (state_q)
            IDLE:    state_d = empty ? IDLE : LAUNCH;
            LAUNCH: begin
                pop     = 1'b1;
                tmo_d   = '0;
                state_d = FEED;
            end
            FEED: begin
                if (done_hit) begin
                    tmo_d   = '0;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    tmo_d   = '0;
                    rec_d   = '0;
                    data_d  = RECOVER_BYTE;
                    terr_d  = 1'b1;
                    state_d = RECOVER;
                end else begin
                    pop   = !empty;
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RECOVER: begin
                rec_d   = rec_q + 1'b1;
                state_d = rec_q == RW'(RECOVER_CYC - 1) ? IDLE : RECOVER;
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            data_d = mem_q[rd_q[AW-1:0]];
            rd_d   = rd_q + 1'b1;
        end
        start_d = state_d == LAUNCH;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            tmo_q   <= '0;
            rec_q   <= '0;
            data_q  <= 8'h00;
            start_q <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            tmo_q   <= tmo_d;
            rec_q   <= rec_d;
            data_q  <= data_d;
            start_q <= start_d;
            terr_q  <= terr_d;
        end
    end

`ifdef DSR_FEEDER_STATS_EN
    logic [7:0] frame_q, frame_d, err_q, err_d;

    always_comb begin
        frame_d = frame_q + {7'd0, done_hit};
        err_d   = err_q + {7'd0, tmo_hit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= 8'h00;
            err_q   <= 8'h00;
        end else begin
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign frame_cnt = frame_q;
    assign err_cnt   = err_q;
`else
    assign frame_cnt = 8'h00;
    assign err_cnt   = 8'h00;
`endif
endmodule

// File: doc/dsr_frame_feeder.md
DSR_FRAME_FEEDER -- requirements
Module: dsr_frame_feeder

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 64: maximum FEED cycles allowed before done is seen.
REQ-003 Parameter RECOVER_CYC, default 4: number of cycles the recovery byte is driven.
REQ-004 Parameter RECOVER_BYTE, default 8'h17: byte driven during recovery.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port in_valid, input, 1 bit: upstream byte valid.
REQ-008 Port in_data, input, 8 bits: upstream byte.
REQ-009 Port in_ready, output, 1 bit: high when the FIFO can accept a byte; equals not-full.
REQ-010 Port dsr_start, output, 1 bit, registered: one-cycle frame start to the downstream sequencer.
REQ-011 Port dsr_data, output, 8 bits, registered: byte stream to the downstream sequencer.
REQ-012 Port dsr_done, input, 1 bit: frame-complete pulse from the downstream sequencer.
REQ-013 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 Port timeout_err, output, 1 bit, registered: one-cycle pulse on timeout.
REQ-015 Port frame_cnt, output, 8 bits: number of completed frames.
REQ-016 Port err_cnt, output, 8 bits: number of timeouts.

Function
REQ-017 A push occurs when in_valid and in_ready are both high; the FIFO SHALL keep byte order, and a push while full SHALL be impossible because in_ready is low.
REQ-018 The FSM states SHALL be IDLE, LAUNCH, FEED and RECOVER.
REQ-019 IDLE: if the FIFO is non-empty, go to LAUNCH; otherwise stay.
REQ-020 LAUNCH: lasts exactly 1 cycle with dsr_start=1; on exit, pop the head byte into dsr_data and go to FEED.
REQ-021 FEED: each cycle the FIFO is non-empty, pop the next byte into dsr_data; when empty, dsr_data holds its last value.
REQ-022 FEED: on dsr_done=1, increment frame_cnt, clear the timeout counter and go to IDLE; bytes left in the FIFO wait for the next frame.
REQ-023 FEED: the timeout counter counts FEED cycles; on the TIMEOUT-th cycle without dsr_done, pulse timeout_err, increment err_cnt and go to RECOVER.
REQ-024 If dsr_done and timeout expiry occur in the same cycle, done SHALL win: no timeout_err, frame_cnt increments.
REQ-025 RECOVER: dsr_data=RECOVER_BYTE for RECOVER_CYC cycles with no pops, then go to IDLE.
REQ-026 dsr_done seen outside FEED SHALL be ignored.
REQ-027 frame_cnt and err_cnt SHALL wrap from 255 to 0.
REQ-028 Pushes are accepted in every state, including the cycle of a pop; a push and a pop in the same cycle leave the occupancy unchanged.

Reset
REQ-029 While rst is high, the block SHALL force: state=IDLE, FIFO empty, dsr_start=0, dsr_data=8'h00, timeout_err=0, frame_cnt=0, err_cnt=0, timeout counter=0.
REQ-030 in_ready SHALL be 1 from the first cycle after rst is released.
REQ-031 Reset asserted mid-frame SHALL discard the FIFO contents and the frame without any pulse on dsr_start or timeout_err.

Configuration
REQ-032 The macro DSR_FEEDER_STATS_EN SHALL control the statistics counters.
REQ-033 With DSR_FEEDER_STATS_EN defined, frame_cnt and err_cnt SHALL behave per REQ-022, REQ-023 and REQ-027.
REQ-034 Without DSR_FEEDER_STATS_EN, frame_cnt and err_cnt SHALL be constant 8'h00 and no counter registers are built; all other behaviour is unchanged.

Verification
REQ-035 Push 8'h03, 8'hAB, 8'h80 with dsr_done at the third FEED cycle -> dsr_start high 1 cycle; dsr_data sequence 03, AB, 80; then IDLE; frame_cnt=1.
REQ-036 Push 5 bytes with DEPTH=4 and no pops -> in_ready goes low after the 4th accepted byte; the 5th byte is held upstream until the first pop.
REQ-037 Start a frame and never assert dsr_done -> timeout_err pulses on FEED cycle 64; dsr_data=8'h17 for 4 cycles; then IDLE; err_cnt=1.
REQ-038 Assert dsr_done in the same cycle the timeout expires -> no timeout_err; frame_cnt increments; err_cnt unchanged.
REQ-039 Assert rst in the second FEED cycle with 2 bytes still queued -> all outputs return to reset values; FIFO empty; in_ready=1 after release.
REQ-040 Build without DSR_FEEDER_STATS_EN and rerun REQ-035 and REQ-037 -> identical dsr_* and timeout_err traces; frame_cnt=err_cnt=0.
